ram_gbf_bank_arb: RTL

//  Multi-bank global-buffer SRAM controller for OFM/GBF storage. Splits one

---
 rtl/gbf_pkg.sv | 17 +
 rtl/ram_gbf_bank.sv | 37 +++
 rtl/ram_gbf_bank_arb.sv | 90 +++++++++
 3 files changed

// File: rtl/gbf_pkg.sv
// Shared sizing and address layout for the banked global-buffer SRAM.
// The address is {bank, row} with the bank index in the MSBs.
package gbf_pkg;
  localparam int NUM_BANK       = 4;
  localparam int BANK_DEPTH_BIT = 8;
  localparam int DATA_WIDTH     = 96;
  localparam int BE_WIDTH       = 12;
  localparam int STARVE_MAX     = 3;
  localparam int BANK_BIT       = $clog2(NUM_BANK);
  localparam int AW             = BANK_BIT + BANK_DEPTH_BIT;
  localparam int STARVE_W       = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [BANK_BIT-1:0]       bank;
    logic [BANK_DEPTH_BIT-1:0] row;
  } gbf_addr_t;
endpackage

// File: rtl/ram_gbf_bank.sv
// One single-port SRAM bank: lane-masked write, write-first 1-cycle read.
// The array has no reset; contents survive a controller reset.
module ram_gbf_bank #(
  parameter int DATA_WIDTH = 96,
  parameter int BE_WIDTH   = 12,
  parameter int ADDR_BIT   = 8
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic [BE_WIDTH-1:0]   be,
  input  logic [ADDR_BIT-1:0]   addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int LW = DATA_WIDTH / BE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BIT];
  logic [DATA_WIDTH-1:0] merged;

  // Word as it looks after this cycle's write; drives dout for write-first.
  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) merged[i*LW +: LW] = din[i*LW +: LW];
    end
  end

  always_ff @(posedge clk) begin
    if (cs) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (we && be[i]) mem[addr][i*LW +: LW] <= din[i*LW +: LW];
      end
      dout <= we ? merged : mem[addr];
    end
  end
endmodule

// File: rtl/ram_gbf_bank_arb.sv
// Banked GBF SRAM controller: arbitrates one read and one write port across
// NUM_BANK single-port banks, write-priority with bounded read starvation.
module ram_gbf_bank_arb
  import gbf_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  // valid/ready: a transfer happens on a posedge where valid & ready are both 1;
  // ready is combinational from valids, addresses and starve state only.
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [AW-1:0]         rd_addr,
  output logic                  rd_dvalid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [15:0]           rd_stall
);
  gbf_addr_t             wa, ra;
  logic                  conflict, read_wins, wr_fire, rd_fire;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [NUM_BANK-1:0]   bank_cs, bank_we;
  logic [DATA_WIDTH-1:0] bank_dout [NUM_BANK];
  logic                  rd_pend;
  logic [BANK_BIT-1:0]   rd_bank_q;

  assign wa = wr_addr;
  assign ra = rd_addr;

  always_comb begin
    conflict  = wr_valid && rd_valid && (wa.bank == ra.bank);
    read_wins = conflict && (starve_cnt == STARVE_W'(STARVE_MAX));
    wr_ready  = !reset && !read_wins;
    rd_ready  = !reset && (!conflict || read_wins);
    wr_fire   = wr_valid && wr_ready;
    rd_fire   = rd_valid && rd_ready;
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic [BANK_DEPTH_BIT-1:0] row;

    assign bank_we[b] = wr_fire && (wa.bank == BANK_BIT'(b));
    assign bank_cs[b] = bank_we[b] || (rd_fire && (ra.bank == BANK_BIT'(b)));
    assign row        = bank_we[b] ? wa.row : ra.row;

    ram_gbf_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .BE_WIDTH   (BE_WIDTH),
      .ADDR_BIT   (BANK_DEPTH_BIT)
    ) u_bank (
      .clk  (clk),
      .cs   (bank_cs[b]),
      .we   (bank_we[b]),
      .be   (wr_be),
      .addr (row),
      .din  (wr_data),
      .dout (bank_dout[b])
    );
  end

  // Starvation only accumulates while a read is actually waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!rd_valid || rd_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend   <= 1'b0;
      rd_bank_q <= '0;
      rd_dvalid <= 1'b0;
      rd_data   <= '0;
      rd_stall  <= '0;
    end else begin
      rd_pend   <= rd_fire;
      if (rd_fire) rd_bank_q <= ra.bank;
      rd_dvalid <= rd_pend;
      if (rd_pend) rd_data <= bank_dout[rd_bank_q];
      if (rd_valid && !rd_ready && rd_stall != 16'hFFFF) rd_stall <= rd_stall + 16'd1;
    end
  end
endmodule
